// File: rtl/operand_drain_arbiter.sv
// Round-robin burst drain of NUM_REQ operand FIFOs onto one registered port.
// Define OPERAND_DRAIN_ARB_XFER_CNT_EN to add the xfer_count output.
module operand_drain_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BEAT_W = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_head,
  output logic [NUM_REQ-1:0]            fifo_pop,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef OPERAND_DRAIN_ARB_XFER_CNT_EN
  ,
  output logic [31:0]                   xfer_count
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(BURST_LEN - 1);
  localparam logic [SRC_W-1:0] LAST_SRC =
    SRC_W'(NUM_REQ - 1);
  localparam logic [SRC_W:0] NREQ_W =
    (SRC_W + 1)'(NUM_REQ);

  state_t                state, state_d;
  logic [SRC_W-1:0]      rr_ptr, rr_d;
  logic [SRC_W-1:0]      grant, grant_d;
  logic [SRC_W-1:0]      grant_nxt, pick;
  logic [SRC_W:0]        idx;
  logic [BEAT_W-1:0]     beat, beat_d;
  logic                  found, load, take;
  logic                  cur_empty;
  logic [DATA_WIDTH-1:0] cur_head;
  logic [DATA_WIDTH-1:0] heads [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_head
    assign heads[i] =
      fifo_head[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cur_head  = heads[grant];
  assign cur_empty = fifo_empty[grant];
  assign load      = ~out_valid | out_ready;
  assign grant_nxt =
    (grant == LAST_SRC) ? '0 : grant + 1'b1;

  // first non-empty FIFO at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = {1'b0, rr_ptr} + (SRC_W + 1)'(j);
      if (idx >= NREQ_W)
        idx = idx - NREQ_W;
      if (!found && !fifo_empty[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    beat_d   = beat;
    rr_d     = rr_ptr;
    take     = 1'b0;
    fifo_pop = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (load) begin
          if (!cur_empty) begin
            take = 1'b1;
            if (beat == LAST_BEAT) begin
              state_d = IDLE;
              rr_d    = grant_nxt;
            end else begin
              beat_d = beat + 1'b1;
            end
          end else begin
            state_d = IDLE;
            rr_d    = grant_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take && !rst)
      fifo_pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      beat   <= '0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_d;
      grant  <= grant_d;
      beat   <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= cur_head;
      out_src   <= grant;
      out_last  <= (beat == LAST_BEAT);
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPERAND_DRAIN_ARB_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      xfer_count <= '0;
    else if (out_valid && out_ready)
      xfer_count <= xfer_count + 32'd1;
  end
`endif

endmodule
